rtc_timekeeper: RTL and testbench
=================================

// Module: rtc_timekeeper
// PURPOSE
//  Parametrised real-time clock: prescales clk into 1 Hz ticks and keeps HH:MM:SS in 24 h form.
//  Adds synchronous time load with range checking, 12/24 h display mode, an HH:MM alarm, and
//  one-cycle event strobes (second, day rollover, alarm) for downstream display/interrupt logic.
// PARAMETERS
//  TICK_DIV  50_000_000  clk cycles per second tick (>=1); prescaler width = max(1,$clog2(TICK_DIV))
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  reset      in   1  asynchronous, active-high; clears all state
//  en         in   1  count enable; low freezes prescaler and time
//  load       in   1  1-cycle load strobe for load_hrs/min/sec
//  load_hrs   in   5  load value, 0..23
//  load_min   in   6  load value, 0..59
//  load_sec   in   6  load value, 0..59
//  mode_12h   in   1  1 = disp_hrs in 12 h form, 0 = 24 h
//  alarm_en   in   1  alarm compare enable
//  alarm_hrs  in   5  alarm hour, 0..23 (24 h form)
//  alarm_min  in   6  alarm minute, 0..59
//  sec        out  6  seconds 0..59 (registered)
//  min        out  6  minutes 0..59 (registered)
//  hrs        out  5  hours 0..23, always 24 h (registered)
//  disp_hrs   out  5  display hour: =hrs, or 1..12 when mode_12h (combinational from hrs)
//  pm         out  1  hrs >= 12, valid in both modes (combinational)
//  sec_tick   out  1  1-cycle pulse, time just advanced
//  day_tick   out  1  1-cycle pulse, time just wrapped 23:59:59 -> 00:00:00
//  alarm_hit  out  1  1-cycle pulse, tick landed on alarm_hrs:alarm_min:00
//  load_err   out  1  1-cycle pulse, load rejected (out of range)
// BEHAVIOUR
//  Reset: prescaler, sec, min, hrs = 0; all pulses = 0; disp_hrs = 0 (24 h) or 12 (12 h); pm = 0.
//  Prescaler: en=1 counts 0..TICK_DIV-1 then wraps to 0; wrap edge = tick. TICK_DIV=1 -> tick each en cycle.
//  Tick: sec+1; sec 59->0 carries min+1; min 59->0 carries hrs+1; hrs 23->0. All update on the tick edge.
//  Pulses registered, asserted exactly the one cycle in which the new time is visible on the outputs.
//  day_tick only on 23:59:59 -> 00:00:00 via tick. Never on load or reset.
//  alarm_hit: alarm_en=1 and post-tick time == alarm_hrs:alarm_min:00. Never on load.
//    Out-of-range alarm values simply never match.
//  Load (any en): all three fields in range -> time := load values, prescaler := 0, no pulses.
//    Any field out of range -> time and prescaler unchanged, load_err pulses next cycle.
//  Load and tick on the same edge: load wins; no sec_tick/day_tick/alarm_hit. Next tick TICK_DIV en-cycles later.
//  en=0: prescaler and time hold; load still honoured; no pulses except load_err.
//  12 h mapping: hrs 0 -> 12 AM; 1..11 -> same, AM; 12 -> 12 PM; 13..23 -> hrs-12, PM.
//  Reset mid-count: immediate async clear; counting restarts from prescaler 0 after release.
//  Internal time never leaves its legal ranges.
// TESTING
//  TICK_DIV=4 with en=1; pulse reset mid-count -> sec/min/hrs, prescaler and pulses read 0 immediately.
//  TICK_DIV=4: load 23:59:58, en=1 -> 23:59:59 after 4 clk; then 00:00:00 with sec_tick and day_tick (1 cycle each).
//  Display mapping, mode_12h=1:
//    load 00:30:00 -> disp_hrs=12, pm=0
//    load 12:00:00 -> disp_hrs=12, pm=1
//    load 13:05:00 -> disp_hrs=1, pm=1
//    switch mode_12h=0 at 13:05:00 -> disp_hrs=13
//  Alarm 07:00, alarm_en=1:
//    load 06:59:59, tick -> alarm_hit once at 07:00:00
//    load 07:00:00 directly -> no alarm_hit
//    repeat the tick case with alarm_en=0 -> no alarm_hit
//  Range check: load 24:00:00 or 10:60:00 -> load_err 1 cycle, time unchanged.
//    Drop en for 10 cycles -> time and prescaler frozen.
//  Assert load on the tick edge (load 05:00:00) -> time 05:00:00, no sec_tick; next sec_tick exactly 4 cycles later.

Source files
------------

// File: rtl/rtc_timekeeper.sv
// Real-time clock: prescales clk into second ticks and keeps HH:MM:SS (24 h) with
// range-checked load, 12/24 h display mapping, an HH:MM alarm and one-cycle event strobes.
module rtc_timekeeper #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       load,
  input  logic [4:0] load_hrs,
  input  logic [5:0] load_min,
  input  logic [5:0] load_sec,
  input  logic       mode_12h,
  input  logic       alarm_en,
  input  logic [4:0] alarm_hrs,
  input  logic [5:0] alarm_min,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hrs,
  output logic [4:0] disp_hrs,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_tick,
  output logic       alarm_hit,
  output logic       load_err
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d;
  logic [5:0]    min_q, min_d;
  logic [4:0]    hrs_q, hrs_d;
  logic          sec_tick_q, sec_tick_d;
  logic          day_tick_q, day_tick_d;
  logic          alarm_hit_q, alarm_hit_d;
  logic          load_err_q, load_err_d;

  logic load_ok;
  logic tick;

  assign load_ok = (load_hrs <= 5'd23) && (load_min <= 6'd59) && (load_sec <= 6'd59);
  assign tick    = en && (presc_q == PRESC_MAX);

  // A load, valid or not, takes priority over a coincident tick; a rejected load
  // leaves time and prescaler exactly as they were.
  always_comb begin
    presc_d     = presc_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hrs_d       = hrs_q;
    sec_tick_d  = 1'b0;
    day_tick_d  = 1'b0;
    alarm_hit_d = 1'b0;
    load_err_d  = 1'b0;

    if (load) begin
      if (load_ok) begin
        sec_d   = load_sec;
        min_d   = load_min;
        hrs_d   = load_hrs;
        presc_d = '0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick) begin
      presc_d    = '0;
      sec_tick_d = 1'b1;
      if (sec_q == 6'd59) begin
        sec_d = 6'd0;
        if (min_q == 6'd59) begin
          min_d = 6'd0;
          if (hrs_q == 5'd23) begin
            hrs_d      = 5'd0;
            day_tick_d = 1'b1;
          end else begin
            hrs_d = hrs_q + 5'd1;
          end
        end else begin
          min_d = min_q + 6'd1;
        end
      end else begin
        sec_d = sec_q + 6'd1;
      end
      alarm_hit_d = alarm_en && (hrs_d == alarm_hrs) && (min_d == alarm_min) && (sec_d == 6'd0);
    end else if (en) begin
      presc_d = presc_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q     <= '0;
      sec_q       <= '0;
      min_q       <= '0;
      hrs_q       <= '0;
      sec_tick_q  <= 1'b0;
      day_tick_q  <= 1'b0;
      alarm_hit_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hrs_q       <= hrs_d;
      sec_tick_q  <= sec_tick_d;
      day_tick_q  <= day_tick_d;
      alarm_hit_q <= alarm_hit_d;
      load_err_q  <= load_err_d;
    end
  end

  always_comb begin
    disp_hrs = hrs_q;
    if (mode_12h) begin
      if (hrs_q == 5'd0)      disp_hrs = 5'd12;
      else if (hrs_q > 5'd12) disp_hrs = hrs_q - 5'd12;
    end
  end

  assign pm        = (hrs_q >= 5'd12);
  assign sec       = sec_q;
  assign min       = min_q;
  assign hrs       = hrs_q;
  assign sec_tick  = sec_tick_q;
  assign day_tick  = day_tick_q;
  assign alarm_hit = alarm_hit_q;
  assign load_err  = load_err_q;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Directed bench for rtc_timekeeper with TICK_DIV=4: reset, rollover, display
// mapping, alarm, load range checking, enable freeze and load-on-tick priority.
module tb_rtc_timekeeper;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [4:0] load_hrs;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       mode_12h;
  logic       alarm_en;
  logic [4:0] alarm_hrs;
  logic [5:0] alarm_min;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hrs;
  logic [4:0] disp_hrs;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;
  logic       alarm_hit;
  logic       load_err;

  int n_checks = 0;
  int n_pass   = 0;

  rtc_timekeeper #(.TICK_DIV(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_hrs  (load_hrs),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .mode_12h  (mode_12h),
    .alarm_en  (alarm_en),
    .alarm_hrs (alarm_hrs),
    .alarm_min (alarm_min),
    .sec       (sec),
    .min       (min),
    .hrs       (hrs),
    .disp_hrs  (disp_hrs),
    .pm        (pm),
    .sec_tick  (sec_tick),
    .day_tick  (day_tick),
    .alarm_hit (alarm_hit),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_time(input string tag, input int h, input int m, input int s);
    check({tag, ".hrs"}, 32'(hrs), 32'(h));
    check({tag, ".min"}, 32'(min), 32'(m));
    check({tag, ".sec"}, 32'(sec), 32'(s));
  endtask

  task automatic do_load(input int h, input int m, input int s);
    load     = 1'b1;
    load_hrs = 5'(h);
    load_min = 6'(m);
    load_sec = 6'(s);
    step(1);
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0;
    load_hrs = '0; load_min = '0; load_sec = '0;
    mode_12h = 1'b0; alarm_en = 1'b0; alarm_hrs = 5'd7; alarm_min = 6'd0;

    // Reset values and display mapping of hour 0
    #2;
    check_time("rst", 0, 0, 0);
    check("rst.sec_tick", 32'(sec_tick), 32'd0);
    check("rst.day_tick", 32'(day_tick), 32'd0);
    check("rst.alarm_hit", 32'(alarm_hit), 32'd0);
    check("rst.load_err", 32'(load_err), 32'd0);
    check("rst.disp24", 32'(disp_hrs), 32'd0);
    check("rst.pm", 32'(pm), 32'd0);
    mode_12h = 1'b1;
    #1;
    check("rst.disp12", 32'(disp_hrs), 32'd12);
    mode_12h = 1'b0;

    // First tick arrives on the 4th enabled edge after release
    step(1);
    reset = 1'b0; en = 1'b1;
    step(3);
    check("cnt.pre", 32'(sec), 32'd0);
    step(1);
    check("cnt.sec", 32'(sec), 32'd1);
    check("cnt.tick", 32'(sec_tick), 32'd1);

    // Async reset while sec_tick is high clears immediately
    reset = 1'b1;
    #1;
    check("arst.sec", 32'(sec), 32'd0);
    check("arst.tick", 32'(sec_tick), 32'd0);
    step(1);
    reset = 1'b0;

    // Reset with prescaler at 2: counting must restart from 0
    step(2);
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step(3);
    check("arst2.pre", 32'(sec), 32'd0);
    step(1);
    check("arst2.sec", 32'(sec), 32'd1);
    check("arst2.tick", 32'(sec_tick), 32'd1);

    // Day rollover
    do_load(23, 59, 58);
    check_time("ld", 23, 59, 58);
    check("ld.tick", 32'(sec_tick), 32'd0);
    step(3);
    check("ld.hold", 32'(sec), 32'd58);
    step(1);
    check_time("t59", 23, 59, 59);
    check("t59.tick", 32'(sec_tick), 32'd1);
    check("t59.day", 32'(day_tick), 32'd0);
    step(3);
    check("t59.tick_off", 32'(sec_tick), 32'd0);
    step(1);
    check_time("wrap", 0, 0, 0);
    check("wrap.tick", 32'(sec_tick), 32'd1);
    check("wrap.day", 32'(day_tick), 32'd1);
    step(1);
    check("wrap.tick_off", 32'(sec_tick), 32'd0);
    check("wrap.day_off", 32'(day_tick), 32'd0);

    // 12 h display mapping
    mode_12h = 1'b1;
    do_load(0, 30, 0);
    check("d0030.disp", 32'(disp_hrs), 32'd12);
    check("d0030.pm", 32'(pm), 32'd0);
    do_load(12, 0, 0);
    check("d1200.disp", 32'(disp_hrs), 32'd12);
    check("d1200.pm", 32'(pm), 32'd1);
    do_load(13, 5, 0);
    check("d1305.disp", 32'(disp_hrs), 32'd1);
    check("d1305.pm", 32'(pm), 32'd1);
    mode_12h = 1'b0;
    #1;
    check("d1305.disp24", 32'(disp_hrs), 32'd13);
    check("d1305.hrs", 32'(hrs), 32'd13);

    // Alarm at 07:00
    alarm_en = 1'b1;
    do_load(6, 59, 59);
    check("al.ld", 32'(alarm_hit), 32'd0);
    step(3);
    check("al.pre", 32'(alarm_hit), 32'd0);
    step(1);
    check_time("al", 7, 0, 0);
    check("al.hit", 32'(alarm_hit), 32'd1);
    step(1);
    check("al.hit_off", 32'(alarm_hit), 32'd0);
    do_load(7, 0, 0);
    check("al.direct", 32'(alarm_hit), 32'd0);
    step(4);
    check_time("al.after", 7, 0, 1);
    check("al.after_hit", 32'(alarm_hit), 32'd0);
    alarm_en = 1'b0;
    do_load(6, 59, 59);
    step(4);
    check_time("al.dis", 7, 0, 0);
    check("al.dis_tick", 32'(sec_tick), 32'd1);
    check("al.dis_hit", 32'(alarm_hit), 32'd0);

    // Range checking with en low
    en = 1'b0;
    do_load(24, 0, 0);
    check("err24.flag", 32'(load_err), 32'd1);
    check_time("err24", 7, 0, 0);
    step(1);
    check("err24.off", 32'(load_err), 32'd0);
    do_load(10, 60, 0);
    check("err60.flag", 32'(load_err), 32'd1);
    check_time("err60", 7, 0, 0);
    do_load(10, 0, 0);
    check("ldok.err", 32'(load_err), 32'd0);
    check_time("ldok", 10, 0, 0);

    // Freeze: prescaler parked at 2 across 10 disabled cycles
    en = 1'b1;
    step(2);
    en = 1'b0;
    step(10);
    check_time("frz", 10, 0, 0);
    check("frz.tick", 32'(sec_tick), 32'd0);
    en = 1'b1;
    step(1);
    check("frz.p3", 32'(sec), 32'd0);
    step(1);
    check("frz.sec", 32'(sec), 32'd1);
    check("frz.tick2", 32'(sec_tick), 32'd1);

    // Load on the tick edge wins; next tick 4 cycles later
    step(3);
    do_load(5, 0, 0);
    check_time("lt", 5, 0, 0);
    check("lt.tick", 32'(sec_tick), 32'd0);
    step(3);
    check("lt.pre", 32'(sec), 32'd0);
    check("lt.pre_tick", 32'(sec_tick), 32'd0);
    step(1);
    check("lt.sec", 32'(sec), 32'd1);
    check("lt.tick2", 32'(sec_tick), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
